// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/writeback over a shared datapath,
// owns the NZCV flags and gates every architectural write with the condition latched in decode.
module arm_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] cond,
  input  logic [3:0] aluFlags,
  output logic       PCWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic       IRWrite,
  output logic       adrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] resultSrc,
  output logic [1:0] immSrc,
  output logic [1:0] regSrc,
  output logic [3:0] ALUControl,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_PASSB = 4'b0101;

  logic [3:0] flags;
  logic [3:0] next_state;
  logic [3:0] dp_ctl;
  logic       dp_nowrite;
  logic       dp_cv;
  logic       cond_ex;
  logic       cond_ex_reg;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       no_write;
  logic       fetch;

  always_comb begin
    dp_ctl     = ALU_ADD;
    dp_nowrite = 1'b0;
    dp_cv      = 1'b0;
    case (funct[4:1])
      4'b0100: begin dp_ctl = ALU_ADD; dp_cv = 1'b1; end
      4'b0010: begin dp_ctl = ALU_SUB; dp_cv = 1'b1; end
      4'b1010: begin dp_ctl = ALU_SUB; dp_cv = 1'b1; dp_nowrite = 1'b1; end
      4'b0000: dp_ctl = ALU_AND;
      4'b1100: dp_ctl = ALU_ORR;
      4'b0001: dp_ctl = ALU_EOR;
      4'b1101: dp_ctl = ALU_PASSB;
      default: dp_nowrite = 1'b1;
    endcase
  end

  // flags = {N,Z,C,V}
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   next_state = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   next_state = S_MEMADR;
          2'b10:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  always_comb begin
    adrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    resultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        resultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECUTER: ALUControl = dp_ctl;
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_ctl;
      end
      S_ALUWB:    reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        resultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // noWrite only applies to data-processing writeback, never to a load's writeback
  assign no_write = (state == S_ALUWB) & dp_nowrite;
  assign fetch    = (state == S_FETCH) & ~reset;
  assign IRWrite  = fetch;
  assign regWrite = reg_w & cond_ex_reg & ~no_write;
  assign memWrite = mem_w & cond_ex_reg;
  assign PCWrite  = fetch | (branch & cond_ex_reg) | (regWrite & (rd == 4'd15));
  assign immSrc   = op;
  assign regSrc   = {op == 2'b01, op == 2'b10};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      flags       <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE)
        cond_ex_reg <= cond_ex;
      if ((state == S_EXECUTER || state == S_EXECUTEI) && cond_ex_reg && funct[0]) begin
        flags[3:2] <= aluFlags[3:2];
        if (dp_cv)
          flags[1:0] <= aluFlags[1:0];
      end
    end
  end

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control word, popped once per cycle.
module tb_arm_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, aluFlags;
  logic       PCWrite, memWrite, regWrite, IRWrite, adrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, resultSrc, immSrc, regSrc;
  logic [3:0] ALUControl, state;

  arm_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond(cond),
    .aluFlags(aluFlags), .PCWrite(PCWrite), .memWrite(memWrite), .regWrite(regWrite),
    .IRWrite(IRWrite), .adrSrc(adrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .resultSrc(resultSrc), .immSrc(immSrc), .regSrc(regSrc), .ALUControl(ALUControl),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] exp;
    logic [21:0] msk;
  } rec_t;

  rec_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] mflags = 4'b0000;
  logic [1:0] cur_op = 2'b00;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010,
                         ORR = 4'b0011, EOR = 4'b0100, PASSB = 4'b0101;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [21:0] observed();
    return {state, PCWrite, memWrite, regWrite, IRWrite, adrSrc, ALUSrcA,
            ALUSrcB, resultSrc, ALUControl, immSrc, regSrc};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // care = {adrSrc, ALUSrcA, ALUSrcB, resultSrc, ALUControl}; state, write enables, immSrc, regSrc always checked
  task automatic push(input logic [3:0] st, input logic pcw, input logic memw, input logic regw,
                      input logic irw, input logic adr, input logic sa, input logic [1:0] sbv,
                      input logic [1:0] rs, input logic [3:0] ac, input logic [4:0] care);
    rec_t r;
    r.exp = {st, pcw, memw, regw, irw, adr, sa, sbv, rs, ac, cur_op, cur_op == 2'b01, cur_op == 2'b10};
    r.msk = {8'hFF, care[4], care[3], {2{care[2]}}, {2{care[1]}}, {4{care[0]}}, 4'hF};
    exp_q.push_back(r);
  endtask

  task automatic exec(input string name, input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] d, input logic [3:0] c, input logic [3:0] af);
    logic       ce, nw, cv;
    logic [3:0] ac;
    rec_t       r;
    int         cyc;
    op = o; funct = f; rd = d; cond = c; aluFlags = af; cur_op = o;
    #1;
    ce = cond_ok(c, mflags);
    push(4'd0, 1, 0, 0, 1, 0, 1, 2'b10, 2'b10, ADD, 5'b11111);
    push(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, ADD, 5'b01101);
    case (o)
      2'b00: begin
        nw = 1'b0; cv = 1'b0; ac = ADD;
        case (f[4:1])
          4'b0100: begin ac = ADD; cv = 1; end
          4'b0010: begin ac = SUB; cv = 1; end
          4'b1010: begin ac = SUB; cv = 1; nw = 1; end
          4'b0000: ac = AND_;
          4'b1100: ac = ORR;
          4'b0001: ac = EOR;
          4'b1101: ac = PASSB;
          default: nw = 1;
        endcase
        push(f[5] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 0, f[5] ? 2'b01 : 2'b00, 2'b00, ac, 5'b01101);
        if (ce && f[0]) begin
          mflags[3:2] = af[3:2];
          if (cv) mflags[1:0] = af[1:0];
        end
        push(4'd8, ce && !nw && d == 4'd15, 0, ce && !nw, 0, 0, 0, 2'b00, 2'b00, ADD, 5'b00010);
      end
      2'b01: begin
        push(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, f[3] ? ADD : SUB, 5'b01101);
        if (f[0]) begin
          push(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, ADD, 5'b10000);
          push(4'd4, ce && d == 4'd15, 0, ce, 0, 0, 0, 2'b00, 2'b01, ADD, 5'b00010);
        end else begin
          push(4'd5, 0, ce, 0, 0, 1, 0, 2'b00, 2'b00, ADD, 5'b10000);
        end
      end
      2'b10: push(4'd9, ce, 0, 0, 0, 0, 0, 2'b01, 2'b10, ADD, 5'b01111);
      default: ;
    endcase
    cyc = 0;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk($sformatf("%s.c%0d", name, cyc), {10'd0, observed() & r.msk}, {10'd0, r.exp & r.msk});
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; op = 2'b00; funct = 6'd0; rd = 4'd0; cond = 4'hE; aluFlags = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_we", {28'd0, PCWrite, IRWrite, regWrite, memWrite}, 32'd0);
    chk("rst_fetch_ctl", {22'd0, adrSrc, ALUSrcA, ALUSrcB, resultSrc, ALUControl},
        {22'd0, 1'b0, 1'b1, 2'b10, 2'b10, ADD});
    reset = 1'b0;
    #1;

    exec("add",      2'b00, 6'b001000, 4'd1,  4'hE, 4'b0000);
    exec("subs",     2'b00, 6'b000101, 4'd2,  4'hE, 4'b0100);
    exec("beq_t",    2'b10, 6'b100000, 4'd0,  4'h0, 4'b0000);
    exec("bne_nt",   2'b10, 6'b100000, 4'd0,  4'h1, 4'b0000);
    exec("ldr_pc",   2'b01, 6'b011001, 4'd15, 4'hE, 4'b0000);
    exec("str",      2'b01, 6'b010000, 4'd3,  4'hE, 4'b0000);
    exec("adds_z0",  2'b00, 6'b001001, 4'd4,  4'hE, 4'b0000);
    exec("streq_nt", 2'b01, 6'b010000, 4'd3,  4'h0, 4'b0000);
    exec("cmp",      2'b00, 6'b010101, 4'd0,  4'hE, 4'b1001);
    exec("bmi_t",    2'b10, 6'b100000, 4'd0,  4'h4, 4'b0000);
    exec("bvs_t",    2'b10, 6'b100000, 4'd0,  4'h6, 4'b0000);
    exec("bge_t",    2'b10, 6'b100000, 4'd0,  4'hA, 4'b0000);
    exec("blt_nt",   2'b10, 6'b100000, 4'd0,  4'hB, 4'b0000);
    exec("movi_pc",  2'b00, 6'b111010, 4'd15, 4'hE, 4'b0000);
    exec("eor",      2'b00, 6'b000010, 4'd5,  4'hE, 4'b0000);
    exec("orr",      2'b00, 6'b011000, 4'd6,  4'hE, 4'b0000);
    exec("and_nv",   2'b00, 6'b000000, 4'd7,  4'hF, 4'b0000);
    exec("undef_op", 2'b00, 6'b001110, 4'd8,  4'hE, 4'b0000);

    // LDR interrupted by reset while in MEMREAD
    op = 2'b01; funct = 6'b011001; rd = 4'd2; cond = 4'hE; cur_op = 2'b01;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_state", {28'd0, state}, 32'd3);
    reset = 1'b1;
    #1;
    mflags = 4'b0000;
    chk("async_rst_state", {28'd0, state}, 32'd0);
    chk("async_rst_we", {28'd0, PCWrite, IRWrite, regWrite, memWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exec("undef_after", 2'b11, 6'b000000, 4'd0, 4'hE, 4'b0000);
    exec("bpl_t",       2'b10, 6'b100000, 4'd0, 4'h5, 4'b0000);
    exec("bhi_nt",      2'b10, 6'b100000, 4'd0, 4'h8, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
